adder_t: RTL and testbench

Leaky-free integrate-and-fire neuron update stage of the SNN accelerator. It collects three partial sums, one from each convolution PE, and the previous membrane potential of one output neuron, all received through the adder depacketizer. It adds them and compares the total against a firing threshold. It returns the new membrane potential and a 1-bit spike to the adder packetizer for transport over the NoC.

---
 rtl/adder_t_if.sv | 40 ++++
 rtl/adder_t.sv | 179 +++++++++++++++++
 tb/tb_adder_t.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/adder_t_if.sv
// rtl/adder_t_if.sv - valid/ready bundle between the adder depacketizer/packetizer and adder_t
interface adder_t_if #(
    parameter int PSUM_W = 8,
    parameter int MEM_W  = 10
);
    logic [PSUM_W-1:0] pe0_data;
    logic              pe0_valid;
    logic              pe0_ready;
    logic [PSUM_W-1:0] pe1_data;
    logic              pe1_valid;
    logic              pe1_ready;
    logic [PSUM_W-1:0] pe2_data;
    logic              pe2_valid;
    logic              pe2_ready;
    logic [MEM_W-1:0]  mem_in_data;
    logic              mem_in_valid;
    logic              mem_in_ready;
    logic [MEM_W-1:0]  mem_out_data;
    logic              mem_out_valid;
    logic              mem_out_ready;
    logic              spike_out;
    logic              spike_valid;
    logic              spike_ready;

    // Producer/consumer side: drives the partial sums and membrane, accepts results
    modport master (
        output pe0_data, pe0_valid, pe1_data, pe1_valid, pe2_data, pe2_valid,
        output mem_in_data, mem_in_valid, mem_out_ready, spike_ready,
        input  pe0_ready, pe1_ready, pe2_ready, mem_in_ready,
        input  mem_out_data, mem_out_valid, spike_out, spike_valid
    );

    // Neuron update stage side
    modport slave (
        input  pe0_data, pe0_valid, pe1_data, pe1_valid, pe2_data, pe2_valid,
        input  mem_in_data, mem_in_valid, mem_out_ready, spike_ready,
        output pe0_ready, pe1_ready, pe2_ready, mem_in_ready,
        output mem_out_data, mem_out_valid, spike_out, spike_valid
    );
endinterface

// File: rtl/adder_t.sv
// rtl/adder_t.sv - integrate-and-fire neuron update; optional ADDER_T_SOFT_RESET_EN selects subtract-threshold reset
module adder_t #(
    parameter int PSUM_W    = 8,
    parameter int MEM_W     = 10,
    parameter int THRESHOLD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    adder_t_if.slave   bus
);
    localparam int SUM_W = MEM_W + 2;
    localparam logic [SUM_W-1:0] THR = SUM_W'(THRESHOLD);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic pe0_cap, pe1_cap, pe2_cap, mem_cap;
    logic [PSUM_W-1:0] pe0_q, pe1_q, pe2_q;
    logic [MEM_W-1:0]  mem_q;

    logic pe0_fire, pe1_fire, pe2_fire, mem_fire;
    logic mem_out_fire, spike_fire;
    logic all_captured;
    logic outputs_drained;

    logic [SUM_W-1:0] sum;
    logic             spike;
    logic [MEM_W-1:0] new_mem;

    assign pe0_fire     = bus.pe0_valid & bus.pe0_ready;
    assign pe1_fire     = bus.pe1_valid & bus.pe1_ready;
    assign pe2_fire     = bus.pe2_valid & bus.pe2_ready;
    assign mem_fire     = bus.mem_in_valid & bus.mem_in_ready;
    assign mem_out_fire = bus.mem_out_valid & bus.mem_out_ready;
    assign spike_fire   = bus.spike_valid & bus.spike_ready;

    // An input counts as held if it was captured earlier or is being captured on this edge
    assign all_captured = (pe0_cap | pe0_fire) & (pe1_cap | pe1_fire) &
                          (pe2_cap | pe2_fire) & (mem_cap | mem_fire);

    // Both results have handed off; this cycle is the turnaround back to collecting
    assign outputs_drained = ~bus.mem_out_valid & ~bus.spike_valid;

    assign sum = SUM_W'(pe0_q) + SUM_W'(pe1_q) + SUM_W'(pe2_q) + SUM_W'(mem_q);
    assign spike = (sum >= THR);

`ifdef ADDER_T_SOFT_RESET_EN
    localparam logic [SUM_W-1:0] MEM_MAX = SUM_W'((1 << MEM_W) - 1);
    logic [SUM_W-1:0] residue;
    assign residue = sum - THR;

    // Spiking keeps the charge above threshold, clipped to the membrane range
    always_comb begin
        new_mem = sum[MEM_W-1:0];
        if (spike) begin
            if (residue > MEM_MAX) begin
                new_mem = '1;
            end else begin
                new_mem = residue[MEM_W-1:0];
            end
        end
    end
`else
    // Spiking discards all charge
    always_comb begin
        new_mem = sum[MEM_W-1:0];
        if (spike) begin
            new_mem = '0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and input readies
    always_comb begin
        state_next       = state;
        bus.pe0_ready    = 1'b0;
        bus.pe1_ready    = 1'b0;
        bus.pe2_ready    = 1'b0;
        bus.mem_in_ready = 1'b0;
        case (state)
            COLLECT: begin
                bus.pe0_ready    = ~pe0_cap;
                bus.pe1_ready    = ~pe1_cap;
                bus.pe2_ready    = ~pe2_cap;
                bus.mem_in_ready = ~mem_cap;
                if (all_captured) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                state_next = SEND;
            end
            SEND: begin
                if (outputs_drained) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Input capture, result registers and output handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe0_cap           <= 1'b0;
            pe1_cap           <= 1'b0;
            pe2_cap           <= 1'b0;
            mem_cap           <= 1'b0;
            pe0_q             <= '0;
            pe1_q             <= '0;
            pe2_q             <= '0;
            mem_q             <= '0;
            bus.mem_out_data  <= '0;
            bus.spike_out     <= 1'b0;
            bus.mem_out_valid <= 1'b0;
            bus.spike_valid   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (pe0_fire) begin
                        pe0_q   <= bus.pe0_data;
                        pe0_cap <= 1'b1;
                    end
                    if (pe1_fire) begin
                        pe1_q   <= bus.pe1_data;
                        pe1_cap <= 1'b1;
                    end
                    if (pe2_fire) begin
                        pe2_q   <= bus.pe2_data;
                        pe2_cap <= 1'b1;
                    end
                    if (mem_fire) begin
                        mem_q   <= bus.mem_in_data;
                        mem_cap <= 1'b1;
                    end
                end
                COMPUTE: begin
                    bus.mem_out_data  <= new_mem;
                    bus.spike_out     <= spike;
                    bus.mem_out_valid <= 1'b1;
                    bus.spike_valid   <= 1'b1;
                end
                SEND: begin
                    if (mem_out_fire) begin
                        bus.mem_out_valid <= 1'b0;
                    end
                    if (spike_fire) begin
                        bus.spike_valid <= 1'b0;
                    end
                    if (outputs_drained) begin
                        pe0_cap <= 1'b0;
                        pe1_cap <= 1'b0;
                        pe2_cap <= 1'b0;
                        mem_cap <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_t.sv
// tb/tb_adder_t.sv - self-checking bench for adder_t
module tb_adder_t;
`ifdef ADDER_T_SOFT_RESET_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_t_if #(.PSUM_W(8), .MEM_W(10)) bus ();

    adder_t #(.PSUM_W(8), .MEM_W(10), .THRESHOLD(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] pe0;
        logic [7:0] pe1;
        logic [7:0] pe2;
        logic [9:0] mem;
        logic [9:0] exp_mem;
        logic       exp_spike;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_readies(input string name, input logic [3:0] exp);
        check(name, {bus.pe0_ready, bus.pe1_ready, bus.pe2_ready, bus.mem_in_ready}, {28'd0, exp});
    endtask

    task automatic idle_inputs();
        bus.pe0_valid = 1'b0;
        bus.pe1_valid = 1'b0;
        bus.pe2_valid = 1'b0;
        bus.mem_in_valid = 1'b0;
    endtask

    // Presents all four inputs together at a falling edge; returns after the capture edge
    task automatic present_all(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [9:0] m);
        bus.pe0_data = a;     bus.pe0_valid = 1'b1;
        bus.pe1_data = b;     bus.pe1_valid = 1'b1;
        bus.pe2_data = c;     bus.pe2_valid = 1'b1;
        bus.mem_in_data = m;  bus.mem_in_valid = 1'b1;
        check_readies("ready_before_capture", 4'b1111);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    // Called one falling edge after the capture edge (COMPUTE cycle)
    task automatic check_result(input string name, input logic [9:0] exp_mem, input logic exp_spike);
        check({name, "_compute_valid"}, {30'd0, bus.mem_out_valid, bus.spike_valid}, 32'd0);
        check_readies({name, "_compute_ready"}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valids"}, {30'd0, bus.mem_out_valid, bus.spike_valid}, 32'd3);
        check({name, "_mem"}, {22'd0, bus.mem_out_data}, {22'd0, exp_mem});
        check({name, "_spike"}, {31'd0, bus.spike_out}, {31'd0, exp_spike});
    endtask

    // Accepts both outputs together and checks the turnaround back to COLLECT
    task automatic drain_both(input string name);
        bus.mem_out_ready = 1'b1;
        bus.spike_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_out_ready = 1'b0;
        bus.spike_ready = 1'b0;
        check({name, "_valids_dropped"}, {30'd0, bus.mem_out_valid, bus.spike_valid}, 32'd0);
        check_readies({name, "_turnaround_ready"}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check_readies({name, "_ready_back"}, 4'b1111);
    endtask

    initial begin
        logic [9:0] held_mem;

        vecs[0] = '{8'd10,  8'd20,  8'd30,  10'd0,    10'd60,                 1'b0};
        vecs[1] = '{8'd10,  8'd20,  8'd30,  10'd5,    SOFT ? 10'd1    : 10'd0, 1'b1};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   10'd0,    10'd0,                  1'b0};
        vecs[3] = '{8'd20,  8'd20,  8'd20,  10'd3,    10'd63,                 1'b0};
        vecs[4] = '{8'd20,  8'd20,  8'd20,  10'd4,    10'd0,                  1'b1};
        vecs[5] = '{8'd255, 8'd255, 8'd255, 10'd1023, SOFT ? 10'd1023 : 10'd0, 1'b1};
        vecs[6] = '{8'd100, 8'd0,   8'd0,   10'd0,    SOFT ? 10'd36   : 10'd0, 1'b1};
        vecs[7] = '{8'd1,   8'd1,   8'd1,   10'd0,    10'd3,                  1'b0};

        idle_inputs();
        bus.pe0_data = '0;
        bus.pe1_data = '0;
        bus.pe2_data = '0;
        bus.mem_in_data = '0;
        bus.mem_out_ready = 1'b0;
        bus.spike_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_valids", {30'd0, bus.mem_out_valid, bus.spike_valid}, 32'd0);
        check("reset_mem_out", {22'd0, bus.mem_out_data}, 32'd0);
        check("reset_spike_out", {31'd0, bus.spike_out}, 32'd0);
        check_readies("reset_ready", 4'b1111);

        for (int i = 0; i < 8; i++) begin
            present_all(vecs[i].pe0, vecs[i].pe1, vecs[i].pe2, vecs[i].mem);
            check_result($sformatf("vec%0d", i), vecs[i].exp_mem, vecs[i].exp_spike);
            drain_both($sformatf("vec%0d", i));
        end

        // Staggered arrival: mem_in, pe2, pe0, pe1, three cycles apart
        bus.mem_in_data = 10'd1; bus.mem_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.mem_in_valid = 1'b0;
        check_readies("stagger_after_mem", 4'b1110);
        repeat (2) @(negedge clk);
        check_readies("stagger_hold_mem", 4'b1110);
        bus.pe2_data = 8'd2; bus.pe2_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.pe2_valid = 1'b0;
        check_readies("stagger_after_pe2", 4'b1100);
        repeat (2) @(negedge clk);
        bus.pe0_data = 8'd3; bus.pe0_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.pe0_valid = 1'b0;
        check_readies("stagger_after_pe0", 4'b0100);
        repeat (2) @(negedge clk);
        bus.pe1_data = 8'd4; bus.pe1_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.pe1_valid = 1'b0;
        check_result("stagger", 10'd10, 1'b0);
        drain_both("stagger");

        // Spike output back-pressured for three cycles while mem_out is taken at once
        present_all(8'd10, 8'd20, 8'd30, 10'd5);
        check_result("bp", SOFT ? 10'd1 : 10'd0, 1'b1);
        held_mem = bus.mem_out_data;
        bus.mem_out_ready = 1'b1;
        bus.spike_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            bus.mem_out_ready = 1'b0;
            check($sformatf("bp_mem_valid_%0d", k), {31'd0, bus.mem_out_valid}, 32'd0);
            check($sformatf("bp_spike_valid_%0d", k), {31'd0, bus.spike_valid}, 32'd1);
            check($sformatf("bp_spike_stable_%0d", k), {31'd0, bus.spike_out}, 32'd1);
            check_readies($sformatf("bp_ready_low_%0d", k), 4'b0000);
        end
        check("bp_mem_data_held", {22'd0, bus.mem_out_data}, {22'd0, held_mem});
        drain_both("bp");

        // Reset while results are pending discards them and any captured inputs
        present_all(8'd50, 8'd50, 8'd50, 10'd50);
        check_result("rst_send", SOFT ? 10'd136 : 10'd0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("rst_send_valids", {30'd0, bus.mem_out_valid, bus.spike_valid}, 32'd0);
        check_readies("rst_send_ready", 4'b1111);

        // Partial capture followed by reset: the stale pe0 must not be reused
        bus.pe0_data = 8'd200; bus.pe0_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.pe0_valid = 1'b0;
        check_readies("partial_capture", 4'b0111);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check_readies("partial_rst_ready", 4'b1111);
        present_all(8'd1, 8'd2, 8'd3, 10'd4);
        check_result("after_rst", 10'd10, 1'b0);
        drain_both("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
